operand_fetch: RTL
==================

Name: operand_fetch

Overview:
- Issue stage directly upstream of the register file. Accepts decoded instructions over a valid/ready handshake and drives the regfile's two synchronous read addresses.
- Captures the read data one cycle later and presents an operand bundle to the execute stage over a second valid/ready handshake.
- Resolves the same-edge write/read hazard of the synchronous-read regfile by snooping the writeback port and forwarding.

Parameters:
- W, 64, data width; must match regfile W.
- AW, 4, register address width; must match regfile AW.
- OPW, 6, opcode width carried alongside operands.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept an instruction this cycle.
- in_opcode  in  OPW  opcode.
- in_rd  in  AW  destination register index, passed through.
- in_rs0  in  AW  source 0 index.
- in_rs1  in  AW  source 1 index.
- rf_r0addr  out  AW  to regfile r0addr.
- rf_r1addr  out  AW  to regfile r1addr.
- rf_r0data  in  W  from regfile r0data.
- rf_r1data  in  W  from regfile r1data.
- wb_wena  in  1  writeback enable, same net as regfile wena.
- wb_waddr  in  AW  writeback address, same net as regfile waddr.
- wb_wdata  in  W  writeback data, same net as regfile wdata.
- out_valid  out  1  operand bundle valid.
- out_ready  in  1  execute stage accepts the bundle.
- out_opcode  out  OPW  held opcode.
- out_rd  out  AW  held destination index.
- out_rs0  out  AW  held source 0 index.
- out_rs1  out  AW  held source 1 index.
- out_op0  out  W  operand 0.
- out_op1  out  W  operand 1.

Behaviour:
- Holding register: stores valid, opcode, rd, rs0 and rs1. An instruction is accepted at a posedge when in_valid && in_ready.
- in_ready = !out_valid || out_ready (combinational). Throughput is one instruction per cycle; no bubble when out_ready is held high.
- Read address mux, combinational: rf_rXaddr = accept ? in_rsX : held rsX. While stalled, the regfile re-reads the held address every cycle, so operands track later writes.
- Forwarding flags: at every posedge, fwdX <= wb_wena && (wb_waddr == rf_rXaddr) and fwdX_data <= wb_wdata. This covers the case where a write and a read of the same index land on the same edge, which returns stale data from the regfile.
- Operand output, combinational: out_opX = fwdX ? fwdX_data : rf_rXdata.
- Latency: instruction accepted at edge E gives out_valid=1 after E, with operands valid in the same cycle.
- out_valid update per edge:
  - accept: out_valid <= 1.
  - else if out_ready: out_valid <= 0.
  - else hold.
- Outputs are stable while out_valid && !out_ready. Exception: out_op0/out_op1 may change when a write to a held source index occurs, and always reflect the latest committed value.
- rs0 == rs1 is legal; both operands get identical data.
- wb write to rd of the held instruction has no special effect unless rd also equals rs0/rs1.
- Reset (including mid-stall): out_valid=0, fwd0=fwd1=0, fwd data=0; opcode/rd/rs held fields=0. in_ready=1 in the first cycle after reset. Any in-flight bundle is dropped.
- No state machine beyond the valid bit; there is no scoreboard. Hazards against instructions still in execute are the producer's responsibility.

Optional Feature:
- Macro: OPERAND_FETCH_R0_ZERO_EN.
- Defined: an operand whose held source index is 0 reads as 0, overriding forwarding and regfile data. Register 0 behaves as hardwired zero.
- Undefined: index 0 is an ordinary register.

Decomposition:
- Shared package holds:
  - W/AW/OPW default constants.
  - Opcode typedef sized OPW.
  - Register-index typedef sized AW.
  - Operand bundle struct: opcode, rd, rs0, rs1, op0, op1.
- One sub-module is natural: fwd_mux. One instance per read port; it contains the fwd flag/data registers and the output mux. Instantiated twice.

Test Plan:
- Regfile preloaded r3=0x11, r5=0x22; issue rs0=3, rs1=5 with out_ready=1 -> next cycle out_valid=1, op0=0x11, op1=0x22.
- Same-edge hazard: issue rs0=7 on the edge where wb writes r7=0xABCD (old value 0) -> op0=0xABCD, not 0.
- Stall: out_ready=0 for 3 cycles with rs1=2; write r2=0x55 in the 2nd stall cycle -> in_ready=0 throughout, op1=0x55 from the following cycle, other fields unchanged.
- Back-to-back: 4 instructions on consecutive cycles, out_ready=1 -> 4 consecutive out_valid cycles, correct operands, in_ready never drops.
- Reset mid-stall: out_valid=1, out_ready=0, assert rst one cycle -> out_valid=0, in_ready=1, and the next issue completes normally.
- With OPERAND_FETCH_R0_ZERO_EN defined: write r0=0xFF, then issue rs0=0 -> op0=0. With the macro undefined -> op0=0xFF.

Source files
------------

// File: rtl/operand_fetch_pkg.sv
// ----------------------------------------------------------------------------
// operand_fetch_pkg
//   Shared types and default sizes for the operand fetch stage.
//   Default W/AW/OPW must agree with the register file the stage drives.
//
//   Optional build macro (consumed by operand_fetch_fwd_mux):
//     OPERAND_FETCH_R0_ZERO_EN - register index 0 reads as hardwired zero.
// ----------------------------------------------------------------------------
package operand_fetch_pkg;

    localparam int W_DEF   = 64;   // data width
    localparam int AW_DEF  = 4;    // register address width
    localparam int OPW_DEF = 6;    // opcode width

    typedef logic [OPW_DEF-1:0] opcode_t;
    typedef logic [AW_DEF-1:0]  reg_idx_t;
    typedef logic [W_DEF-1:0]   data_t;

    // Operand bundle handed to execute.
    typedef struct packed {
        opcode_t  opcode;
        reg_idx_t rd;
        reg_idx_t rs0;
        reg_idx_t rs1;
        data_t    op0;
        data_t    op1;
    } operand_bundle_t;

endpackage

// File: rtl/operand_fetch_fwd_mux.sv
// ----------------------------------------------------------------------------
// operand_fetch_fwd_mux
//   One per regfile read port. Remembers whether the writeback on the edge
//   that launched the synchronous read targeted the same index. If so, the
//   regfile returns the pre-write value, and the captured writeback data is
//   presented instead.
//
//   Optional build macro:
//     OPERAND_FETCH_R0_ZERO_EN - a held source index of 0 yields operand 0,
//                                overriding both forwarding and regfile data.
//
//   Ports:
//     clk, rst      clock, synchronous active-high reset
//     wb_wena_i     writeback enable (same net as regfile wena)
//     wb_waddr_i    writeback address
//     wb_wdata_i    writeback data
//     raddr_i       address presented to the regfile read port this cycle
//     rdata_i       regfile read data (for the address of the previous edge)
//     held_idx_i    source index of the held instruction
//     op_o          resolved operand
// ----------------------------------------------------------------------------
module operand_fetch_fwd_mux
    import operand_fetch_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wb_wena_i,
    input  logic [AW-1:0] wb_waddr_i,
    input  logic [W-1:0]  wb_wdata_i,
    input  logic [AW-1:0] raddr_i,
    input  logic [W-1:0]  rdata_i,
    input  logic [AW-1:0] held_idx_i,
    output logic [W-1:0]  op_o
);

    logic         fwd_q, fwd_d;
    logic [W-1:0] fwd_data_q;
    logic [W-1:0] sel_data;

    // Same-edge write/read of one index: the regfile read misses the write.
    assign fwd_d = wb_wena_i && (wb_waddr_i == raddr_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            fwd_q      <= fwd_d;
            fwd_data_q <= wb_wdata_i;
        end
    end

    assign sel_data = fwd_q ? fwd_data_q : rdata_i;

`ifdef OPERAND_FETCH_R0_ZERO_EN
    assign op_o = (held_idx_i == '0) ? '0 : sel_data;
`else
    // Index 0 is an ordinary register; the held index is not needed here.
    logic unused_held_idx;
    assign unused_held_idx = ^held_idx_i;
    assign op_o = sel_data;
`endif

endmodule

// File: rtl/operand_fetch.sv
// ----------------------------------------------------------------------------
// operand_fetch
//   Issue stage feeding a synchronous-read register file. Accepts a decoded
//   instruction, drives the two regfile read addresses, and one cycle later
//   presents the operand bundle to execute. Writebacks landing on the same
//   edge as a read are forwarded; while stalled, the held source addresses
//   are re-read every cycle so operands follow later writes.
//
//   Optional build macro:
//     OPERAND_FETCH_R0_ZERO_EN - register 0 reads as hardwired zero.
//
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     in_valid / in_ready      upstream handshake
//     in_opcode/in_rd/in_rs0/in_rs1  decoded instruction fields
//     rf_r0addr/rf_r1addr      regfile read addresses
//     rf_r0data/rf_r1data      regfile read data
//     wb_wena/wb_waddr/wb_wdata  writeback snoop (same nets as regfile write)
//     out_valid / out_ready    downstream handshake
//     out_opcode/out_rd/out_rs0/out_rs1  held instruction fields
//     out_op0/out_op1          resolved operands
// ----------------------------------------------------------------------------
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int W   = W_DEF,
    parameter int AW  = AW_DEF,
    parameter int OPW = OPW_DEF
) (
    input  logic           clk,
    input  logic           rst,

    input  logic           in_valid,
    output logic           in_ready,
    input  logic [OPW-1:0] in_opcode,
    input  logic [AW-1:0]  in_rd,
    input  logic [AW-1:0]  in_rs0,
    input  logic [AW-1:0]  in_rs1,

    output logic [AW-1:0]  rf_r0addr,
    output logic [AW-1:0]  rf_r1addr,
    input  logic [W-1:0]   rf_r0data,
    input  logic [W-1:0]   rf_r1data,

    input  logic           wb_wena,
    input  logic [AW-1:0]  wb_waddr,
    input  logic [W-1:0]   wb_wdata,

    output logic           out_valid,
    input  logic           out_ready,
    output logic [OPW-1:0] out_opcode,
    output logic [AW-1:0]  out_rd,
    output logic [AW-1:0]  out_rs0,
    output logic [AW-1:0]  out_rs1,
    output logic [W-1:0]   out_op0,
    output logic [W-1:0]   out_op1
);

    logic           valid_q, valid_d;
    logic [OPW-1:0] opcode_q;
    logic [AW-1:0]  rd_q, rs0_q, rs1_q;
    logic           accept;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;
        if (accept)         valid_d = 1'b1;
        else if (out_ready) valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            opcode_q <= '0;
            rd_q     <= '0;
            rs0_q    <= '0;
            rs1_q    <= '0;
        end else begin
            valid_q <= valid_d;
            if (accept) begin
                opcode_q <= in_opcode;
                rd_q     <= in_rd;
                rs0_q    <= in_rs0;
                rs1_q    <= in_rs1;
            end
        end
    end

    // New instruction reads its own sources; otherwise keep re-reading the
    // held ones so a stalled bundle sees later writebacks.
    assign rf_r0addr = accept ? in_rs0 : rs0_q;
    assign rf_r1addr = accept ? in_rs1 : rs1_q;

    operand_fetch_fwd_mux #(.W(W), .AW(AW)) u_fwd0 (
        .clk        (clk),
        .rst        (rst),
        .wb_wena_i  (wb_wena),
        .wb_waddr_i (wb_waddr),
        .wb_wdata_i (wb_wdata),
        .raddr_i    (rf_r0addr),
        .rdata_i    (rf_r0data),
        .held_idx_i (rs0_q),
        .op_o       (out_op0)
    );

    operand_fetch_fwd_mux #(.W(W), .AW(AW)) u_fwd1 (
        .clk        (clk),
        .rst        (rst),
        .wb_wena_i  (wb_wena),
        .wb_waddr_i (wb_waddr),
        .wb_wdata_i (wb_wdata),
        .raddr_i    (rf_r1addr),
        .rdata_i    (rf_r1data),
        .held_idx_i (rs1_q),
        .op_o       (out_op1)
    );

    assign out_valid  = valid_q;
    assign out_opcode = opcode_q;
    assign out_rd     = rd_q;
    assign out_rs0    = rs0_q;
    assign out_rs1    = rs1_q;

endmodule
